mem_arbiter: RTL and testbench

- Shares one unified single-ported memory between the pipeline's instruction fetch bus (imem_*) and its data memory bus (dmem_*).
- Sits between the pipeline top level and the external memory/SoC bus.
- Sequences one transaction at a time. Data gets priority by default, with a starvation limit that guarantees fetch progress.
- Registers all memory-side outputs and all completion strobes.

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and data requests onto one single-ported memory
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] imem_addr,
    input  logic        imem_addr_valid,
    output logic [63:0] imem_data,
    output logic        imem_data_valid,
    input  logic [63:0] dmem_addr,
    input  logic [63:0] dmem_dout,
    output logic [63:0] dmem_din,
    input  logic [1:0]  dmem_write_width,
    input  logic        dmem_rstrobe,
    input  logic        dmem_wstrobe,
    output logic        dmem_cycle_complete,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic [1:0]  mem_width,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ack,
    output logic        grant_dmem
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, IFETCH, DACCESS, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] starve_cnt;
    logic       d_req;
    logic       i_req;
    logic       grant_i;
    logic       grant_d;
    logic       ifetch_done;
    logic       dacc_done;
    logic       fetch_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_i)      state_nxt = IFETCH;
                else if (grant_d) state_nxt = DACCESS;
            end
            IFETCH, DACCESS: if (mem_ack) state_nxt = DONE;
            DONE:            state_nxt = IDLE;
            default:         state_nxt = IDLE;
        endcase
    end

    // Fetch wins only when starved or when there is no data request.
    always_comb begin
        d_req       = dmem_rstrobe | dmem_wstrobe;
        i_req       = imem_addr_valid;
        grant_i     = (state == IDLE) && i_req && ((starve_cnt == LIMIT) || !d_req);
        grant_d     = (state == IDLE) && d_req && !grant_i;
        ifetch_done = (state == IFETCH) && mem_ack;
        dacc_done   = (state == DACCESS) && mem_ack;
        fetch_ok    = imem_addr_valid && (imem_addr == mem_addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_data           <= '0;
            imem_data_valid     <= 1'b0;
            dmem_din            <= '0;
            dmem_cycle_complete <= 1'b0;
            mem_addr            <= '0;
            mem_wdata           <= '0;
            mem_width           <= '0;
            mem_read            <= 1'b0;
            mem_write           <= 1'b0;
            grant_dmem          <= 1'b0;
            starve_cnt          <= '0;
        end else begin
            imem_data_valid     <= 1'b0;
            dmem_cycle_complete <= 1'b0;
            if (grant_i) begin
                mem_addr   <= imem_addr;
                mem_width  <= 2'b11;
                mem_read   <= 1'b1;
                mem_write  <= 1'b0;
                grant_dmem <= 1'b0;
                starve_cnt <= '0;
            end else if (grant_d) begin
                mem_addr   <= dmem_addr;
                mem_wdata  <= dmem_dout;
                mem_width  <= dmem_write_width;
                mem_write  <= dmem_wstrobe;
                mem_read   <= ~dmem_wstrobe;
                grant_dmem <= 1'b1;
                if (!i_req)                   starve_cnt <= '0;
                else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
            end
            // A redirected fetch still completes on the bus but is not reported.
            if (ifetch_done) begin
                mem_read <= 1'b0;
                if (fetch_ok) begin
                    imem_data       <= mem_rdata;
                    imem_data_valid <= 1'b1;
                end
            end
            if (dacc_done) begin
                if (mem_read) dmem_din <= mem_rdata;
                mem_read            <= 1'b0;
                mem_write           <= 1'b0;
                dmem_cycle_complete <= 1'b1;
            end
            if (state == DONE) grant_dmem <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic        imem_addr_valid;
    logic [63:0] imem_data;
    logic        imem_data_valid;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_dout;
    logic [63:0] dmem_din;
    logic [1:0]  dmem_write_width;
    logic        dmem_rstrobe;
    logic        dmem_wstrobe;
    logic        dmem_cycle_complete;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic [1:0]  mem_width;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ack;
    logic        grant_dmem;

    int nvec;
    int nerr;
    int starve;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid),
        .imem_data(imem_data), .imem_data_valid(imem_data_valid),
        .dmem_addr(dmem_addr), .dmem_dout(dmem_dout), .dmem_din(dmem_din),
        .dmem_write_width(dmem_write_width), .dmem_rstrobe(dmem_rstrobe),
        .dmem_wstrobe(dmem_wstrobe), .dmem_cycle_complete(dmem_cycle_complete),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_width(mem_width), .mem_read(mem_read), .mem_write(mem_write),
        .mem_ack(mem_ack), .grant_dmem(grant_dmem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level arbitration rule and starvation bookkeeping.
    task automatic model_grant(input bit i, input bit d, output bit to_imem);
        to_imem = i && (starve == LIMIT || !d);
        if (to_imem)    starve = 0;
        else if (!i)    starve = 0;
        else if (starve < LIMIT) starve = starve + 1;
    endtask

    task automatic clear_reqs();
        imem_addr_valid = 1'b0;
        dmem_rstrobe    = 1'b0;
        dmem_wstrobe    = 1'b0;
    endtask

    task automatic wait_issue(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack_mem(input logic [63:0] rd, input int lat);
        repeat (lat) @(negedge clk);
        mem_rdata = rd;
        mem_ack   = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_reqs();
        imem_addr = '0; dmem_addr = '0; dmem_dout = '0; dmem_write_width = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        starve = 0;
        repeat (3) @(negedge clk);
        nvec++;
        if ({imem_data, imem_data_valid, dmem_din, dmem_cycle_complete, mem_addr, mem_wdata,
             mem_width, mem_read, mem_write, grant_dmem} !== '0) begin
            nerr++; $display("FAIL reset_outputs: some output nonzero, required all 0");
        end
        rst_n = 1'b1;
        @(negedge clk);
        nvec++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            nerr++; $display("FAIL reset_idle: read=%b write=%b, required 0 0", mem_read, mem_write);
        end
    endtask

    task automatic test_single_fetch();
        bit to_i;
        imem_addr = 64'h1000; imem_addr_valid = 1'b1;
        model_grant(1'b1, 1'b0, to_i);
        @(negedge clk);
        nvec++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_width !== 2'b11 ||
            mem_addr !== 64'h1000 || grant_dmem !== 1'b0) begin
            nerr++; $display("FAIL fetch_issue: rd=%b wr=%b w=%b a=%h g=%b, required 1 0 11 1000 0",
                             mem_read, mem_write, mem_width, mem_addr, grant_dmem);
        end
        ack_mem(64'hDEADBEEF_00000001, 2);
        nvec++;
        if (imem_data_valid !== 1'b1 || imem_data !== 64'hDEADBEEF_00000001 ||
            dmem_cycle_complete !== 1'b0 || mem_read !== 1'b0) begin
            nerr++; $display("FAIL fetch_done: v=%b d=%h dc=%b rd=%b, required 1 deadbeef00000001 0 0",
                             imem_data_valid, imem_data, dmem_cycle_complete, mem_read);
        end
        clear_reqs();
        @(negedge clk);
        nvec++;
        if (imem_data_valid !== 1'b0) begin
            nerr++; $display("FAIL fetch_pulse_width: valid=%b, required 0", imem_data_valid);
        end
    endtask

    task automatic test_store();
        bit to_i, ok;
        dmem_addr = 64'h2008; dmem_dout = 64'hAB; dmem_write_width = 2'b00; dmem_wstrobe = 1'b1;
        model_grant(1'b0, 1'b1, to_i);
        wait_issue(ok);
        nvec++;
        if (!ok || mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 64'h2008 ||
            mem_wdata !== 64'hAB || mem_width !== 2'b00 || grant_dmem !== 1'b1) begin
            nerr++; $display("FAIL store_issue: ok=%b wr=%b rd=%b a=%h wd=%h w=%b g=%b, required 1 1 0 2008 ab 00 1",
                             ok, mem_write, mem_read, mem_addr, mem_wdata, mem_width, grant_dmem);
        end
        ack_mem(64'h55, 1);
        nvec++;
        if (dmem_cycle_complete !== 1'b1 || imem_data_valid !== 1'b0 || grant_dmem !== 1'b1) begin
            nerr++; $display("FAIL store_done: dc=%b iv=%b g=%b, required 1 0 1",
                             dmem_cycle_complete, imem_data_valid, grant_dmem);
        end
        clear_reqs();
        @(negedge clk);
        nvec++;
        if (dmem_cycle_complete !== 1'b0 || grant_dmem !== 1'b0 || mem_write !== 1'b0) begin
            nerr++; $display("FAIL store_after: dc=%b g=%b wr=%b, required 0 0 0",
                             dmem_cycle_complete, grant_dmem, mem_write);
        end
    endtask

    task automatic test_starvation();
        logic [9:0] pat;
        bit to_i, ok;
        pat = 10'b10_0001_0000;
        imem_addr = 64'h1000; imem_addr_valid = 1'b1;
        dmem_addr = 64'h2000; dmem_rstrobe = 1'b1; dmem_write_width = 2'b10;
        for (int k = 0; k < 10; k++) begin
            model_grant(1'b1, 1'b1, to_i);
            wait_issue(ok);
            nvec++;
            if (!ok || grant_dmem !== !pat[k] || to_i !== pat[k]) begin
                nerr++; $display("FAIL starve_order[%0d]: ok=%b grant_dmem=%b model_imem=%b, required grant_dmem=%b",
                                 k, ok, grant_dmem, to_i, !pat[k]);
                break;
            end
            ack_mem(64'h100 + 64'(k), $urandom_range(0, 2));
        end
        clear_reqs();
        @(negedge clk);
    endtask

    task automatic test_cancel();
        bit to_i, ok;
        imem_addr = 64'h1000; imem_addr_valid = 1'b1;
        model_grant(1'b1, 1'b0, to_i);
        wait_issue(ok);
        imem_addr = 64'h4000;
        ack_mem(64'h1111, 1);
        nvec++;
        if (!ok || imem_data_valid !== 1'b0 || mem_read !== 1'b0) begin
            nerr++; $display("FAIL cancel_suppress: ok=%b valid=%b rd=%b, required 1 0 0",
                             ok, imem_data_valid, mem_read);
        end
        model_grant(1'b1, 1'b0, to_i);
        wait_issue(ok);
        nvec++;
        if (!ok || mem_addr !== 64'h4000 || mem_read !== 1'b1) begin
            nerr++; $display("FAIL cancel_refetch: ok=%b a=%h rd=%b, required 1 4000 1", ok, mem_addr, mem_read);
        end
        ack_mem(64'h2222, 0);
        nvec++;
        if (imem_data_valid !== 1'b1 || imem_data !== 64'h2222) begin
            nerr++; $display("FAIL cancel_refetch_data: v=%b d=%h, required 1 2222", imem_data_valid, imem_data);
        end
        clear_reqs();
        @(negedge clk);
    endtask

    task automatic test_both_strobes();
        bit to_i, ok;
        dmem_addr = 64'h3000; dmem_dout = 64'h77; dmem_write_width = 2'b11;
        dmem_rstrobe = 1'b1; dmem_wstrobe = 1'b1;
        model_grant(1'b0, 1'b1, to_i);
        wait_issue(ok);
        nvec++;
        if (!ok || mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 64'h3000) begin
            nerr++; $display("FAIL both_issue: ok=%b wr=%b rd=%b a=%h, required 1 1 0 3000",
                             ok, mem_write, mem_read, mem_addr);
        end
        ack_mem(64'h0, 2);
        clear_reqs();
        nvec++;
        if (dmem_cycle_complete !== 1'b1) begin
            nerr++; $display("FAIL both_done: dc=%b, required 1", dmem_cycle_complete);
        end
        @(negedge clk);
        nvec++;
        if (dmem_cycle_complete !== 1'b0 || mem_write !== 1'b0 || mem_read !== 1'b0) begin
            nerr++; $display("FAIL both_single: dc=%b wr=%b rd=%b, required 0 0 0",
                             dmem_cycle_complete, mem_write, mem_read);
        end
    endtask

    task automatic test_ack_in_idle();
        mem_rdata = 64'h9999;
        mem_ack   = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b0;
        @(negedge clk);
        nvec++;
        if (imem_data_valid !== 1'b0 || dmem_cycle_complete !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            nerr++; $display("FAIL idle_ack: iv=%b dc=%b rd=%b wr=%b, required 0 0 0 0",
                             imem_data_valid, dmem_cycle_complete, mem_read, mem_write);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            bit          iv, rs, ws, to_i, ok, perturb;
            logic [63:0] ia, da, dd, rd;
            logic [1:0]  w;
            iv = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            ws = 1'($urandom_range(0, 1));
            if (!(iv | rs | ws)) iv = 1'b1;
            ia = {$urandom, $urandom}; da = {$urandom, $urandom};
            dd = {$urandom, $urandom}; rd = {$urandom, $urandom};
            w  = 2'($urandom_range(0, 3));
            imem_addr = ia; imem_addr_valid = iv;
            dmem_addr = da; dmem_dout = dd; dmem_write_width = w;
            dmem_rstrobe = rs; dmem_wstrobe = ws;
            model_grant(iv, rs | ws, to_i);
            wait_issue(ok);
            nvec++;
            if (!ok) begin
                nerr++; $display("FAIL rnd_issue[%0d]: no request issued within 8 cycles", n);
                break;
            end
            nvec++;
            if (grant_dmem !== !to_i || mem_addr !== (to_i ? ia : da) ||
                mem_read !== (to_i ? 1'b1 : !ws) || mem_write !== (to_i ? 1'b0 : ws) ||
                mem_width !== (to_i ? 2'b11 : w) || (!to_i && mem_wdata !== dd)) begin
                nerr++; $display("FAIL rnd_fields[%0d]: g=%b a=%h rd=%b wr=%b w=%b wd=%h, required g=%b a=%h",
                                 n, grant_dmem, mem_addr, mem_read, mem_write, mem_width, mem_wdata,
                                 !to_i, to_i ? ia : da);
            end
            perturb = ($urandom_range(0, 2) == 0);
            if (perturb) begin
                if (!to_i) begin
                    dmem_rstrobe = 1'b0; dmem_wstrobe = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    imem_addr_valid = 1'b0;
                end else begin
                    imem_addr = ia ^ 64'h8;
                end
            end
            ack_mem(rd, $urandom_range(0, 3));
            nvec++;
            if (imem_data_valid !== (to_i && !perturb) || dmem_cycle_complete !== !to_i ||
                (to_i && !perturb && imem_data !== rd) || (!to_i && !ws && dmem_din !== rd) ||
                mem_read !== 1'b0 || mem_write !== 1'b0) begin
                nerr++; $display("FAIL rnd_done[%0d]: iv=%b dc=%b id=%h dd=%h rd=%b wr=%b, required iv=%b dc=%b data=%h",
                                 n, imem_data_valid, dmem_cycle_complete, imem_data, dmem_din,
                                 mem_read, mem_write, to_i && !perturb, !to_i, rd);
            end
        end
        clear_reqs();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_txn();
        bit to_i, ok;
        imem_addr = 64'h1000; imem_addr_valid = 1'b1;
        model_grant(1'b1, 1'b0, to_i);
        wait_issue(ok);
        @(negedge clk);
        rst_n = 1'b0;
        clear_reqs();
        #1;
        nvec++;
        if (!ok || {imem_data, imem_data_valid, dmem_din, dmem_cycle_complete, mem_addr, mem_wdata,
                    mem_width, mem_read, mem_write, grant_dmem} !== '0) begin
            nerr++; $display("FAIL async_reset: ok=%b rd=%b a=%h id=%h, required all outputs 0",
                             ok, mem_read, mem_addr, imem_data);
        end
        starve = 0;
        @(negedge clk);
        rst_n = 1'b1;
        imem_addr = 64'h5000; imem_addr_valid = 1'b1;
        model_grant(1'b1, 1'b0, to_i);
        wait_issue(ok);
        nvec++;
        if (!ok || mem_addr !== 64'h5000 || mem_read !== 1'b1) begin
            nerr++; $display("FAIL post_reset_issue: ok=%b a=%h rd=%b, required 1 5000 1", ok, mem_addr, mem_read);
        end
        ack_mem(64'hCAFE, 1);
        nvec++;
        if (imem_data_valid !== 1'b1 || imem_data !== 64'hCAFE) begin
            nerr++; $display("FAIL post_reset_data: v=%b d=%h, required 1 cafe", imem_data_valid, imem_data);
        end
        clear_reqs();
        @(negedge clk);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_single_fetch();
        test_store();
        test_starvation();
        test_cancel();
        test_both_strobes();
        test_ack_in_idle();
        test_random();
        test_reset_mid_txn();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
